// File: rtl/vis_readout_scheduler_pkg.sv
// Shared constants for the visibility readout scheduler: default geometry,
// bus address width, words per bank and FSM state encodings.
package vis_readout_scheduler_pkg;

  localparam int ACCUM_DEF = 24;
  localparam int TRATE_DEF = 12;
  localparam int TBITS_DEF = 4;
  localparam int BBITS_DEF = 4;
  localparam int LBITS_DEF = 24;

  function automatic int abits_f(input int tbits, input int bbits);
    return 3 + tbits + bbits;
  endfunction

  function automatic int words_f(input int trate, input int bbits);
    return (1 << bbits) * trate * 8;
  endfunction

  localparam int ABITS_DEF = abits_f(TBITS_DEF, BBITS_DEF);
  localparam int WORDS_DEF = words_f(TRATE_DEF, BBITS_DEF);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SWAP = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_PUSH = 3'd4;

endpackage

// File: rtl/vis_addr_walker.sv
// Bank address walker: word is the innermost index, then slot (skipping
// slots TRATE..2^TBITS-1), then block. Wraps to 0 after the final word.
module vis_addr_walker
  import vis_readout_scheduler_pkg::*;
#(
  parameter int TRATE = TRATE_DEF,
  parameter int TBITS = TBITS_DEF,
  parameter int BBITS = BBITS_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic                     step_i,
  input  logic                     clear_i,
  output logic [2+TBITS+BBITS:0]   adr_o,
  output logic                     last_o
);

  logic [2:0]       r_word;
  logic [TBITS-1:0] r_slot;
  logic [BBITS-1:0] r_blk;
  logic             w_word_end;
  logic             w_slot_end;
  logic             w_blk_end;

  assign w_word_end = (r_word == 3'd7);
  assign w_slot_end = (r_slot == TBITS'(TRATE - 1));
  assign w_blk_end  = &r_blk;
  assign adr_o      = {r_blk, r_slot, r_word};
  assign last_o     = w_word_end && w_slot_end && w_blk_end;

  // Nested counter; the slot field jumps straight from TRATE-1 back to 0
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= 3'd0;
      r_slot <= '0;
      r_blk  <= '0;
    end else if (clear_i) begin
      r_word <= 3'd0;
      r_slot <= '0;
      r_blk  <= '0;
    end else if (step_i) begin
      r_word <= r_word + 3'd1;
      if (w_word_end) begin
        if (w_slot_end) begin
          r_slot <= '0;
          r_blk  <= r_blk + BBITS'(1'b1);
        end else begin
          r_slot <= r_slot + TBITS'(1'b1);
        end
      end
    end
  end

endmodule

// File: rtl/vis_readout_scheduler.sv
// Counts correlator samples, requests a bank switch after the programmed
// accumulation length, then reads the inactive bank out word by word.
module vis_readout_scheduler
  import vis_readout_scheduler_pkg::*;
#(
  parameter int ACCUM = ACCUM_DEF,
  parameter int TRATE = TRATE_DEF,
  parameter int TBITS = TBITS_DEF,
  parameter int BBITS = BBITS_DEF,
  parameter int ABITS = abits_f(TBITS, BBITS),
  parameter int LBITS = LBITS_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic             strobe_i,
  input  logic [LBITS-1:0] acc_len_i,
  output logic             sw_o,
  input  logic             sw_ack_i,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic             bst_o,
  output logic [ABITS-1:0] adr_o,
  input  logic [ACCUM-1:0] dat_i,
  input  logic             ack_i,
  output logic             vld_o,
  output logic [ACCUM-1:0] dat_o,
  output logic             last_o,
  input  logic             rdy_i,
  output logic             busy_o,
  output logic             overrun_o,
  output logic [15:0]      frames_o
);

  logic [2:0]       r_state;
  logic [LBITS-1:0] r_cnt;
  logic             r_expd;
  logic             r_ovr;
  logic             r_sw;
  logic             r_cyc;
  logic             r_stb;
  logic             r_bst;
  logic             r_vld;
  logic             r_last;
  logic [ACCUM-1:0] r_dat;
  logic [15:0]      r_frames;

  logic [LBITS-1:0] w_lim;
  logic [LBITS-1:0] w_cnt_inc;
  logic             w_exp_evt;
  logic             w_hs;
  logic             w_clear;
  logic             w_walk_last;
  logic [ABITS-1:0] w_adr;

  // A programmed length of 0 behaves as 1
  assign w_lim     = (acc_len_i == '0) ? LBITS'(1'b1) : acc_len_i;
  assign w_cnt_inc = r_cnt + LBITS'(1'b1);
  assign w_exp_evt = enable_i && strobe_i && !r_expd && (w_cnt_inc >= w_lim);
  assign w_hs      = (r_state == S_PUSH) && r_vld && rdy_i;
  assign w_clear   = (r_state == S_SWAP) && sw_ack_i;

  vis_addr_walker #(
    .TRATE (TRATE),
    .TBITS (TBITS),
    .BBITS (BBITS)
  ) u_walker (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .step_i  (w_hs),
    .clear_i (w_clear),
    .adr_o   (w_adr),
    .last_o  (w_walk_last)
  );

  // Accumulation counter; r_expd marks an expiry still waiting for its switch
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_expd <= 1'b0;
    end else if (!enable_i) begin
      r_cnt  <= '0;
      r_expd <= 1'b0;
    end else if (w_clear) begin
      r_cnt  <= strobe_i ? LBITS'(1'b1) : '0;
      r_expd <= 1'b0;
    end else if (w_exp_evt) begin
      r_cnt  <= w_lim;
      r_expd <= 1'b1;
    end else if (strobe_i && !r_expd) begin
      r_cnt  <= w_cnt_inc;
    end
  end

  // Sticky overrun: expiry while a switch/readout is still in progress
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_ovr <= 1'b0;
    end else if (!enable_i) begin
      r_ovr <= 1'b0;
    end else if (w_exp_evt && (r_state != S_IDLE)) begin
      r_ovr <= 1'b1;
    end
  end

  // Switch / bus read / stream handshake sequencer
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_sw     <= 1'b0;
      r_cyc    <= 1'b0;
      r_stb    <= 1'b0;
      r_bst    <= 1'b0;
      r_vld    <= 1'b0;
      r_last   <= 1'b0;
      r_dat    <= '0;
      r_frames <= 16'd0;
    end else begin
      r_sw <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable_i && (r_expd || w_exp_evt)) begin
            r_sw    <= 1'b1;
            r_state <= S_SWAP;
          end
        end
        S_SWAP: begin
          if (sw_ack_i) begin
            r_state <= S_ADDR;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_bst   <= 1'b1;
          end
        end
        S_ADDR: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_stb <= 1'b0;
          if (ack_i) begin
            r_cyc   <= 1'b0;
            r_vld   <= 1'b1;
            r_dat   <= dat_i;
            r_last  <= w_walk_last;
            r_state <= S_PUSH;
          end
        end
        S_PUSH: begin
          if (rdy_i) begin
            r_vld  <= 1'b0;
            r_last <= 1'b0;
            if (r_last) begin
              r_state  <= S_IDLE;
              r_bst    <= 1'b0;
              r_frames <= r_frames + 16'd1;
            end else begin
              r_state <= S_ADDR;
              r_cyc   <= 1'b1;
              r_stb   <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cyc   <= 1'b0;
          r_stb   <= 1'b0;
          r_bst   <= 1'b0;
          r_vld   <= 1'b0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  assign sw_o      = r_sw;
  assign cyc_o     = r_cyc;
  assign stb_o     = r_stb;
  assign we_o      = 1'b0;
  assign bst_o     = r_bst;
  assign adr_o     = w_adr;
  assign vld_o     = r_vld;
  assign dat_o     = r_dat;
  assign last_o    = r_last;
  assign busy_o    = (r_state != S_IDLE);
  assign overrun_o = r_ovr;
  assign frames_o  = r_frames;

endmodule

// File: tb/tb_vis_readout_scheduler.sv
// Randomized bench: bus slave with random latency and stray acks, random
// stream back-pressure, and a reference built from the address formula.
module tb_vis_readout_scheduler;
  import vis_readout_scheduler_pkg::*;

  localparam int ACCUM  = ACCUM_DEF;
  localparam int TRATE  = TRATE_DEF;
  localparam int TBITS  = TBITS_DEF;
  localparam int ABITS  = ABITS_DEF;
  localparam int LBITS  = LBITS_DEF;
  localparam int NWORDS = WORDS_DEF;

  logic             clk_i = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable_i = 1'b0;
  logic             strobe_i = 1'b0;
  logic [LBITS-1:0] acc_len_i = '0;
  logic             sw_ack_i = 1'b0;
  logic [ACCUM-1:0] dat_i = '0;
  logic             ack_i = 1'b0;
  logic             rdy_i = 1'b0;
  logic             sw_o, cyc_o, stb_o, we_o, bst_o, vld_o, last_o, busy_o, overrun_o;
  logic [ABITS-1:0] adr_o;
  logic [ACCUM-1:0] dat_o;
  logic [15:0]      frames_o;

  int n_cmp = 0;
  int n_bad = 0;

  vis_readout_scheduler dut (
    .clk_i(clk_i), .rst_n(rst_n), .enable_i(enable_i), .strobe_i(strobe_i),
    .acc_len_i(acc_len_i), .sw_o(sw_o), .sw_ack_i(sw_ack_i), .cyc_o(cyc_o),
    .stb_o(stb_o), .we_o(we_o), .bst_o(bst_o), .adr_o(adr_o), .dat_i(dat_i),
    .ack_i(ack_i), .vld_o(vld_o), .dat_o(dat_o), .last_o(last_o), .rdy_i(rdy_i),
    .busy_o(busy_o), .overrun_o(overrun_o), .frames_o(frames_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Address of the n-th word of a bank: word, then slot 0..TRATE-1, then block
  function automatic logic [31:0] ref_addr(input int n);
    int w, s, b;
    w = n % 8;
    s = (n / 8) % TRATE;
    b = n / (8 * TRATE);
    return 32'((b << (3 + TBITS)) + (s << 3) + w);
  endfunction

  // Reference state kept by the monitor
  int               req_idx = 0;
  int               hs_idx = 0;
  int               frames_ref = 0;
  int               sw_cycles = 0;
  logic [ACCUM-1:0] dq[$];

  // Bus slave, stream sink and scoreboard, all sampling one step after posedge
  initial begin
    logic             pend;
    int               dly;
    int               stall;
    logic             stall_done;
    logic             prev_hold;
    logic [ACCUM-1:0] prev_dat;
    logic [ACCUM-1:0] exp_dat;
    pend = 1'b0; dly = 0; stall = 0; stall_done = 1'b0; prev_hold = 1'b0; prev_dat = '0;
    forever begin
      @(posedge clk_i);
      #1;
      ack_i = 1'b0;
      if (!rst_n) begin
        pend = 1'b0; req_idx = 0; hs_idx = 0; frames_ref = 0;
        dq.delete(); rdy_i = 1'b0; prev_hold = 1'b0; stall = 0; stall_done = 1'b0;
      end else begin
        if (sw_o) sw_cycles++;
        if (sw_ack_i) begin
          req_idx = 0; hs_idx = 0; dq.delete(); stall_done = 1'b0;
        end
        if (prev_hold) begin
          check_eq("hold_vld", vld_o, 1'b1);
          check_eq("hold_dat", dat_o, prev_dat);
          check_eq("hold_cyc", cyc_o, 1'b0);
        end
        if (cyc_o && stb_o && !pend) begin
          check_eq("adr", adr_o, ref_addr(req_idx));
          check_eq("slot_range", adr_o[TBITS+2:3] < TRATE, 1'b1);
          check_eq("req_bst", bst_o, 1'b1);
          if (req_idx == 8 * TRATE) check_eq("slot_wrap", adr_o, 32'(1 << (3 + TBITS)));
          pend = 1'b1;
          dly = $urandom_range(1, 3);
          req_idx++;
        end else if (pend) begin
          dly--;
          if (dly == 0) begin
            ack_i = 1'b1;
            dat_i = ACCUM'($urandom);
            dq.push_back(dat_i);
            pend = 1'b0;
          end
        end else if (!cyc_o && ($urandom_range(0, 7) == 0)) begin
          ack_i = 1'b1;
          dat_i = ACCUM'($urandom);
        end
        if (vld_o) begin
          check_eq("vld_cyc", cyc_o, 1'b0);
          check_eq("vld_bst", bst_o, 1'b1);
          if (hs_idx == 100 && !stall_done) begin
            stall = 10;
            stall_done = 1'b1;
          end
          if (stall > 0) begin
            rdy_i = 1'b0;
            stall--;
          end else begin
            rdy_i = ($urandom_range(0, 3) != 0);
          end
          if (rdy_i) begin
            check_eq("q_depth", dq.size(), 1);
            exp_dat = (dq.size() > 0) ? dq.pop_front() : '0;
            check_eq("dat", dat_o, exp_dat);
            check_eq("last", last_o, (hs_idx == NWORDS - 1));
            hs_idx++;
            if (hs_idx == NWORDS) frames_ref++;
            prev_hold = 1'b0;
          end else begin
            prev_hold = 1'b1;
            prev_dat = dat_o;
          end
        end else begin
          rdy_i = 1'($urandom_range(0, 1));
          prev_hold = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic pulse_strobe(input int gap);
    strobe_i = 1'b1;
    tick();
    strobe_i = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic ack_switch();
    tick();
    tick();
    sw_ack_i = 1'b1;
    tick();
    sw_ack_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy_o && n < 20000) begin
      tick();
      n++;
    end
    check_eq({tag, "_idle"}, busy_o, 1'b0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_sw"}, sw_o, 1'b0);
    check_eq({tag, "_cyc"}, cyc_o, 1'b0);
    check_eq({tag, "_stb"}, stb_o, 1'b0);
    check_eq({tag, "_we"}, we_o, 1'b0);
    check_eq({tag, "_bst"}, bst_o, 1'b0);
    check_eq({tag, "_adr"}, adr_o, 32'd0);
    check_eq({tag, "_vld"}, vld_o, 1'b0);
    check_eq({tag, "_dat"}, dat_o, 32'd0);
    check_eq({tag, "_last"}, last_o, 1'b0);
    check_eq({tag, "_busy"}, busy_o, 1'b0);
    check_eq({tag, "_ovr"}, overrun_o, 1'b0);
    check_eq({tag, "_frames"}, frames_o, 32'd0);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) tick();
    check_outputs_zero("rst");
    rst_n = 1'b1;

    // Plain accumulation of 4 strobes followed by a full bank walk
    enable_i = 1'b1;
    acc_len_i = LBITS'(4);
    tick();
    repeat (3) pulse_strobe($urandom_range(0, 3));
    check_eq("sw_early", sw_o, 1'b0);
    strobe_i = 1'b1;
    tick();
    strobe_i = 1'b0;
    check_eq("sw_pulse", sw_o, 1'b1);
    check_eq("busy_swap", busy_o, 1'b1);
    tick();
    check_eq("sw_width", sw_o, 1'b0);
    tick();
    sw_ack_i = 1'b1;
    tick();
    sw_ack_i = 1'b0;
    wait_idle("walk1");
    check_eq("words1", hs_idx, NWORDS);
    check_eq("frames1", frames_o, 32'd1);
    check_eq("frames1_ref", frames_o, frames_ref);
    check_eq("sw_cnt1", sw_cycles, 1);
    check_eq("bst_end1", bst_o, 1'b0);
    check_eq("ovr1", overrun_o, 1'b0);

    // acc_len=2 with strobes continuing during readout: overrun and deferred switch
    acc_len_i = LBITS'(2);
    pulse_strobe($urandom_range(0, 2));
    strobe_i = 1'b1;
    tick();
    strobe_i = 1'b0;
    check_eq("sw2", sw_o, 1'b1);
    ack_switch();
    repeat (20) tick();
    pulse_strobe($urandom_range(1, 4));
    check_eq("ovr_early", overrun_o, 1'b0);
    pulse_strobe(2);
    check_eq("ovr_set", overrun_o, 1'b1);
    repeat (3) pulse_strobe(1);
    check_eq("sw_busy", sw_o, 1'b0);
    wait_idle("walk2");
    check_eq("sw_not_before", sw_o, 1'b0);
    check_eq("frames2", frames_o, 32'd2);
    tick();
    check_eq("sw_deferred", sw_o, 1'b1);
    check_eq("busy_deferred", busy_o, 1'b1);
    ack_switch();
    wait_idle("walk3");
    check_eq("frames3", frames_o, 32'd3);
    check_eq("frames3_ref", frames_o, frames_ref);
    check_eq("ovr_sticky", overrun_o, 1'b1);
    check_eq("sw_cnt3", sw_cycles, 3);
    enable_i = 1'b0;
    tick();
    check_eq("ovr_clear", overrun_o, 1'b0);

    // acc_len=0 treated as 1, then asynchronous reset in the middle of a read
    enable_i = 1'b1;
    acc_len_i = '0;
    tick();
    strobe_i = 1'b1;
    tick();
    strobe_i = 1'b0;
    check_eq("sw_len0", sw_o, 1'b1);
    ack_switch();
    n = 0;
    while (!(cyc_o && !stb_o) && n < 2000) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    check_eq("wait_found", cyc_o && !stb_o, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    strobe_i = 1'b1;
    tick();
    strobe_i = 1'b0;
    check_eq("sw_after_rst", sw_o, 1'b1);
    ack_switch();
    wait_idle("walk4");
    check_eq("words4", hs_idx, NWORDS);
    check_eq("frames4", frames_o, 32'd1);
    check_eq("frames4_ref", frames_o, frames_ref);
    check_eq("sw_cnt4", sw_cycles, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
